// File: rtl/pipelined_addsub_flags_if.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_flags_if
//
// Purpose:
//   Bundles the operand-side and result-side handshakes of the pipelined
//   adder/subtractor into one interface.
//
// Handshake rule (both sides): a beat transfers on a rising clk edge when
//   valid and ready are both 1 in the cycle before that edge. The producer
//   of a beat owns valid and the payload; the receiver owns ready.
//
// Signals:
//   in_valid, in_ready       operand beat handshake
//   in_x, in_y  [WIDTH]      operands
//   in_sub                   0: add, 1: subtract
//   in_cin                   carry-in used for add only
//   out_valid, out_ready     result beat handshake
//   out_z       [WIDTH]      result
//   out_carry, out_sign, out_parity, out_zero, out_overflow   result flags
//
// Modports:
//   master  - the environment side (operand producer + result consumer)
//   slave   - the arithmetic block
// -----------------------------------------------------------------------------
interface pipelined_addsub_flags_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_sub;
    logic             in_cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic             out_carry;
    logic             out_sign;
    logic             out_parity;
    logic             out_zero;
    logic             out_overflow;

    modport master (
        output in_valid, in_x, in_y, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_z, out_carry, out_sign,
               out_parity, out_zero, out_overflow
    );

    modport slave (
        input  in_valid, in_x, in_y, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_z, out_carry, out_sign,
               out_parity, out_zero, out_overflow
    );
endinterface

// File: rtl/pipelined_addsub_flags.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_flags
//
// Purpose:
//   Pipelined WIDTH-bit adder/subtractor. Each of the NSTG = WIDTH/CHUNK
//   stages adds one CHUNK-bit slice and registers its carry into the next
//   stage. A final output register holds the result together with its
//   carry/sign/parity/zero/overflow flags. A beat accepted at edge N appears
//   on the outputs after edge N+NSTG when the consumer does not stall.
//
// Parameters:
//   WIDTH  operand/result width, a multiple of CHUNK and >= CHUNK
//   CHUNK  bits added per stage
//   The interface instance connected to bus must use the same WIDTH.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; clears every stage and output
//   bus   slave side of pipelined_addsub_flags_if (operand and result
//         valid/ready handshakes, operands, result, flags)
//
// Flow control:
//   The whole pipeline moves as one unit: adv = ~out_valid | out_ready.
//   When adv is low every register (valid bits, data, carries, outputs)
//   holds, so the presented result is stable while the consumer stalls.
//   in_ready is adv itself, so accept and emit can share a cycle.
// -----------------------------------------------------------------------------
module pipelined_addsub_flags #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    pipelined_addsub_flags_if.slave  bus
);
    localparam int NSTG = WIDTH / CHUNK;
    localparam int LST  = NSTG - 1;

    // ---------------------------------------------------------------------
    // Stage registers. Stage k holds the operands, the partial sum with
    // slices 0..k filled in, and the carry out of slice k.
    // The y operand is stored already conditionally inverted (y'), so the
    // stages never look at the sub flag; it travels along only so the
    // overflow rule at the end can tell add from subtract.
    // ---------------------------------------------------------------------
    logic             r_vld [NSTG];
    logic [WIDTH-1:0] r_x   [NSTG];
    logic [WIDTH-1:0] r_yp  [NSTG];
    logic [WIDTH-1:0] r_sum [NSTG];
    logic             r_c   [NSTG];
    logic             r_sub [NSTG];

    // Output register
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_z;
    logic             r_out_carry;
    logic             r_out_sign;
    logic             r_out_parity;
    logic             r_out_zero;
    logic             r_out_overflow;

    // Stage inputs (what each stage sees before its edge) and its results
    logic             w_st_vld  [NSTG];
    logic [WIDTH-1:0] w_st_x    [NSTG];
    logic [WIDTH-1:0] w_st_yp   [NSTG];
    logic [WIDTH-1:0] w_st_sum  [NSTG];
    logic             w_st_cin  [NSTG];
    logic             w_st_sub  [NSTG];
    logic [CHUNK:0]   w_slice   [NSTG];
    logic [WIDTH-1:0] w_nxt_sum [NSTG];

    logic             w_adv;
    logic             w_accept;

    // Final-sum flag terms
    logic [WIDTH-1:0] w_fin_z;
    logic             w_x_msb;
    logic             w_y_msb;
    logic             w_ovf;

    assign w_adv    = ~r_out_valid | bus.out_ready;
    assign w_accept = bus.in_valid & w_adv;

    // ---------------------------------------------------------------------
    // Stage input selection and per-slice addition
    // ---------------------------------------------------------------------
    always_comb begin
        // Stage 0 takes the operand beat directly. Subtract is x + ~y + 1,
        // so the initial carry is forced to 1 and cin is ignored.
        w_st_vld[0] = w_accept;
        w_st_x[0]   = bus.in_x;
        w_st_yp[0]  = bus.in_sub ? ~bus.in_y : bus.in_y;
        w_st_sum[0] = '0;
        w_st_cin[0] = bus.in_sub | bus.in_cin;
        w_st_sub[0] = bus.in_sub;

        for (int k = 1; k < NSTG; k++) begin
            w_st_vld[k] = r_vld[k-1];
            w_st_x[k]   = r_x[k-1];
            w_st_yp[k]  = r_yp[k-1];
            w_st_sum[k] = r_sum[k-1];
            w_st_cin[k] = r_c[k-1];
            w_st_sub[k] = r_sub[k-1];
        end

        for (int k = 0; k < NSTG; k++) begin
            // CHUNK+1 bit result: the top bit is the carry into slice k+1
            w_slice[k] = {1'b0, w_st_x[k][k*CHUNK +: CHUNK]}
                       + {1'b0, w_st_yp[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, w_st_cin[k]};
            w_nxt_sum[k] = w_st_sum[k];
            w_nxt_sum[k][k*CHUNK +: CHUNK] = w_slice[k][CHUNK-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Flags from the completed sum in the last stage
    // ---------------------------------------------------------------------
    assign w_fin_z = r_sum[LST];
    assign w_x_msb = r_x[LST][WIDTH-1];
    // Recover the original y MSB from the stored y'
    assign w_y_msb = r_sub[LST] ? ~r_yp[LST][WIDTH-1] : r_yp[LST][WIDTH-1];
    // Signed overflow: operands that can overflow (same sign for add,
    // opposite sign for sub) and a result whose sign differs from x.
    assign w_ovf   = (r_sub[LST] ? (w_x_msb != w_y_msb) : (w_x_msb == w_y_msb))
                   & (w_fin_z[WIDTH-1] != w_x_msb);

    // ---------------------------------------------------------------------
    // Pipeline and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld[k] <= 1'b0;
                r_x[k]   <= '0;
                r_yp[k]  <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_sub[k] <= 1'b0;
            end
            r_out_valid    <= 1'b0;
            r_out_z        <= '0;
            r_out_carry    <= 1'b0;
            r_out_sign     <= 1'b0;
            r_out_parity   <= 1'b0;
            r_out_zero     <= 1'b0;
            r_out_overflow <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld[k] <= w_st_vld[k];
                r_x[k]   <= w_st_x[k];
                r_yp[k]  <= w_st_yp[k];
                r_sum[k] <= w_nxt_sum[k];
                r_c[k]   <= w_slice[k][CHUNK];
                r_sub[k] <= w_st_sub[k];
            end
            // Bubbles load don't-care data here; consumers look only at
            // beats with out_valid set.
            r_out_valid    <= r_vld[LST];
            r_out_z        <= w_fin_z;
            r_out_carry    <= r_c[LST];
            r_out_sign     <= w_fin_z[WIDTH-1];
            r_out_parity   <= ~^w_fin_z;
            r_out_zero     <= (w_fin_z == '0);
            r_out_overflow <= w_ovf;
        end
    end

    assign bus.in_ready     = w_adv;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_z        = r_out_z;
    assign bus.out_carry    = r_out_carry;
    assign bus.out_sign     = r_out_sign;
    assign bus.out_parity   = r_out_parity;
    assign bus.out_zero     = r_out_zero;
    assign bus.out_overflow = r_out_overflow;

endmodule

// File: tb/tb_pipelined_addsub_flags.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub_flags
//
// Self-checking bench for pipelined_addsub_flags (WIDTH=16, CHUNK=4).
// Results are packed as {z[15:0], carry, sign, parity, zero, overflow}.
// The reference model works on plain integers: unsigned sum/difference for
// the result and carry, signed sum/difference for overflow.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub_flags;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NSTG  = WIDTH / CHUNK;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_addsub_flags_if #(.WIDTH(WIDTH)) bus ();

    pipelined_addsub_flags #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [20:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_emit   = 0;
    bit          rand_ordy = 1'b0;

    // Values sampled in the most recent step
    logic        s_acc;
    logic        s_emit;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [20:0] s_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic sub, input logic cin);
        int          ux, uy, sx, sy, ures, sres;
        logic [15:0] z;
        logic        c, ov, par;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sub) begin
            ures = ux - uy;
            c    = (ux >= uy);           // carry set means no borrow
            sres = sx - sy;
        end else begin
            ures = ux + uy + int'(cin);
            c    = (ures >= 65536);
            sres = sx + sy + int'(cin);
        end
        z   = 16'(ures & 32'hFFFF);
        ov  = (sres > 32767) || (sres < -32768);
        par = (($countones(z) % 2) == 0);
        return {z, c, z[15], par, (z == 16'h0000), ov};
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: drive at the falling edge, sample 1ns later, and
    // account for whatever handshakes will complete at the next rising edge.
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y,
                        input logic sub, input logic cin, input logic ordy,
                        input logic [20:0] expv);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_sub    = sub;
        bus.in_cin    = cin;
        bus.out_ready = rand_ordy ? 1'($urandom_range(0, 1)) : ordy;
        #1;
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_obs       = {bus.out_z, bus.out_carry, bus.out_sign, bus.out_parity,
                       bus.out_zero, bus.out_overflow};
        s_acc       = v & bus.in_ready;
        s_emit      = bus.out_valid & bus.out_ready;
        if (s_emit) begin
            n_emit++;
            check("emit_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("result", 32'(s_obs), 32'(exp_q.pop_front()));
        end
        if (s_acc) exp_q.push_back(expv);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy, 21'h0);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic sub,
                        input logic cin, input logic ordy, input logic [20:0] expv);
        int tries = 0;
        do begin
            step(1'b1, x, y, sub, cin, ordy, expv);
            tries++;
        end while (!s_acc && tries < 50);
        check("send_accept", 32'(s_acc), 1);
    endtask

    task automatic send_rand(input logic ordy);
        logic [15:0] x, y;
        logic        sub, cin;
        x   = 16'($urandom_range(0, 65535));
        y   = 16'($urandom_range(0, 65535));
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        send(x, y, sub, cin, ordy, model(x, y, sub, cin));
    endtask

    task automatic offer_rand(input logic ordy);
        logic [15:0] x, y;
        logic        sub, cin;
        x   = 16'($urandom_range(0, 65535));
        y   = 16'($urandom_range(0, 65535));
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        step(1'b1, x, y, sub, cin, ordy, model(x, y, sub, cin));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_z"}, 32'(bus.out_z), 0);
        check({tag, "_flags"}, 32'({bus.out_carry, bus.out_sign, bus.out_parity,
                                    bus.out_zero, bus.out_overflow}), 0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          n;
        int          e0;
        logic [20:0] snap;

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("reset");

        // 1: 0x7FFF + 1 -> signed overflow, latency NSTG edges
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h8000, 5'b01001});
        n = 0;
        do begin
            idle(1'b1);
            n++;
        end while (!s_out_valid && n < 20);
        check("t1_latency", 32'(n - 1), NSTG);

        // 2: wrap to zero, then the same operands with carry-in
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h0000, 5'b10110});
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, {16'h0001, 5'b10000});
        // 3: subtraction with borrow, and signed overflow on subtract.
        // 0x7FFF has fifteen ones, so its even-parity flag is 0.
        send(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1, {16'hFFFE, 5'b01000});
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, {16'h7FFF, 5'b10001});
        drain();

        // 4: eight back-to-back random beats, results on consecutive cycles
        e0 = n_emit;
        for (int i = 0; i < 8; i++) begin
            send_rand(1'b1);
            check("t4_in_ready", 32'(s_in_ready), 1);
        end
        check("t4_emit_mid", 32'(n_emit - e0), 3);
        repeat (5) idle(1'b1);
        check("t4_emit_all", 32'(n_emit - e0), 8);

        // 5: stall mid-stream for six cycles while offering new beats
        e0 = n_emit;
        for (int i = 0; i < 6; i++) send_rand(1'b1);
        for (int i = 0; i < 6; i++) begin
            offer_rand(1'b0);
            check("t5_out_valid", 32'(s_out_valid), 1);
            check("t5_in_ready", 32'(s_in_ready), 0);
            if (i == 0) snap = s_obs;
            else check("t5_frozen", 32'(s_obs), 32'(snap));
        end
        drain();
        check("t5_emit_count", 32'(n_emit - e0), 6);

        // 6: reset with three beats in flight
        e0 = n_emit;
        for (int i = 0; i < 3; i++) send_rand(1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("t6_reset");
        exp_q.delete();
        repeat (10) idle(1'b1);
        check("t6_no_emit", 32'(n_emit - e0), 0);

        // 7: random traffic with random consumer back-pressure
        rand_ordy = 1'b1;
        for (int i = 0; i < 40; i++) send_rand(1'b1);
        rand_ordy = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
